jericalla_fetch_core: RTL and testbench
=======================================

Name: jericalla_fetch_core

Overview:
- Single-cycle 32-bit MIPS-subset processor core: fetch stage (PC, instruction memory, next-PC logic) plus the "Jericalla mejorada" execute path (decode, register file, ALU, data memory, write-back).
- The fetch stage supplies the current instruction. The execute path returns the branch-taken flag and the sign-extended immediate that fetch uses to compute the branch target.
- One instruction completes per rising clock edge.

Parameters:
- IMEM_DEPTH, 64, instruction memory words; index = pc[7:2].
- DMEM_DEPTH, 64, data memory words; index = addr[7:2].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_we  in  1  instruction-memory load strobe.
- imem_waddr  in  6  instruction word index to load.
- imem_wdata  in  32  instruction word to load.
- dbg_reg_addr  in  5  register-file debug read address.
- dbg_reg_data  out  32  combinational read of register dbg_reg_addr (r0 reads 0).
- pc  out  32  current program counter.
- instruction  out  32  combinational imem[pc[7:2]].
- signal_extended  out  32  extended imm[15:0] of the current instruction.
- branch_equal  out  1  1 when the current instruction is beq and rs == rt.

Behaviour:
- Reset (rising edge with rst_n=0):
  - pc <= 0.
  - All 32 registers <= 0.
  - All data-memory words <= 0.
  - No store is performed that cycle.
  - Instruction memory is NOT cleared.
- Outputs while reset is applied follow the combinational rules from pc=0.
- imem_we=1 writes imem[imem_waddr] on the edge, in reset or not. The new word is visible on `instruction` the next cycle.
- Opcode values (instruction[31:26]) and their operations:
  - 0x00, R-type, by funct:
    - 0x20 add
    - 0x22 sub
    - 0x24 and
    - 0x25 or
    - 0x2A slt (signed)
    - rd <= result
    - All other funct values, including the all-zero word, are NOP.
  - 0x08 addi: rt <= rs + sext(imm).
  - 0x0A slti: signed compare with sext(imm).
  - 0x0C andi: zero-extended imm.
  - 0x0D ori: zero-extended imm.
  - 0x23 lw: rt <= dmem[(rs+sext(imm))[7:2]].
  - 0x2B sw: dmem[(rs+sext(imm))[7:2]] <= rt.
  - 0x04 beq: branch if rs == rt.
  - 0x02 j: pc <= {pc_plus4[31:28], target26, 2'b00}.
  - Undefined opcodes are NOP; pc advances by 4.
- signal_extended: always {{16{imm[15]}}, imm}, regardless of opcode. andi/ori use the zero-extended form internally only.
- Arithmetic: 32-bit, two's complement, overflow ignored (wraps, no trap).
- Next PC, by priority:
  - j target, if the instruction is j.
  - Otherwise pc+4+(signal_extended<<2), if branch_equal.
  - Otherwise pc+4.
- Address wrap: pc is a full 32-bit counter; fetch uses pc[7:2], so instruction memory aliases modulo 64 words.
- Data-memory addresses ignore bits [1:0] (no misalignment fault) and alias modulo 64 words.
- Register file:
  - Two combinational read ports plus the debug port.
  - One write port, written on the rising edge.
  - Writes to r0 are discarded.
  - Reads in the same cycle as a write return the old value.
- Latency: results are visible on dbg_reg_data the cycle after the instruction's edge. A lw result is available to the immediately following instruction.
- Reset mid-program: the reset edge wins over any write-back or store in flight. Execution resumes at pc=0 on the first edge with rst_n=1.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 edges with imem empty (zeros) -> pc=0, dbg_reg_data=0 for every address. After release, pc=4, 8, 12 on successive edges (NOP stream).
- ALU program:
  - addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; sub r4,r1,r2; slt r5,r2,r1; andi r6,r2,0xFFFF
  - -> r3=2, r4=8, r5=1, r6=0x0000FFFD.
  - signal_extended=0xFFFFFFFD during addi r2.
- Memory: addi r1,r0,0x40; sw r1,4(r1); lw r7,4(r1) -> r7=0x40. Then lw r8,0x100(r0) aliases word 0 -> r8=0 after reset.
- Branch:
  - With r1=r2=7, beq r1,r2,+2 at pc=0x10 -> branch_equal=1 and the next pc=0x1C.
  - With r1=7, r2=8 -> branch_equal=0 and the next pc=0x14.
  - Backward beq imm=0xFFFF -> next pc = pc.
- Jump/r0: j 0x000003 -> next pc=0x0C. addi r0,r0,9 -> r0 reads 0. Invalid opcode 0x3F -> no state change except pc+4.
- Reset mid-run: assert rst_n=0 on the same edge as sw r1,0(r0) with r1=0x55 -> dmem word 0 stays 0, pc=0, r1=0.

Source files
------------

// File: rtl/jericalla_fetch_core.sv
// jericalla_fetch_core: single-cycle MIPS-subset core.
// Fetch (PC, instruction memory, next-PC select) feeds the decode/regfile/ALU/
// data-memory execute path, which returns branch_equal and the sign-extended
// immediate used for the branch target.
module jericalla_fetch_core #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_we,
  input  logic [5:0]  imem_waddr,
  input  logic [31:0] imem_wdata,
  input  logic [4:0]  dbg_reg_addr,
  output logic [31:0] dbg_reg_data,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic [31:0] signal_extended,
  output logic        branch_equal
);

  localparam int unsigned IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);
  localparam int unsigned NREGS   = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [31:0] r_pc;
  logic [31:0] r_imem [IMEM_DEPTH];
  logic [31:0] r_regs [NREGS];
  logic [31:0] r_dmem [DMEM_DEPTH];

  logic [31:0]        w_instr;
  logic [5:0]         w_op;
  logic [4:0]         w_rs;
  logic [4:0]         w_rt;
  logic [4:0]         w_rd;
  logic [4:0]         w_shamt;
  logic [5:0]         w_funct;
  logic [15:0]        w_imm;
  logic [31:0]        w_sext;
  logic [31:0]        w_zext;
  logic [31:0]        w_rs_val;
  logic [31:0]        w_rt_val;
  logic [31:0]        w_mem_addr;
  logic [DMEM_AW-1:0] w_mem_idx;
  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_br_target;
  logic [31:0]        w_j_target;
  logic [31:0]        w_pc_next;
  logic               w_reg_we;
  logic [4:0]         w_wr_addr;
  logic [31:0]        w_wr_data;
  logic               w_mem_we;
  logic               w_is_beq;
  logic               w_is_j;
  logic               w_branch_equal;
  logic               w_unused;

  // Fetch and field decode
  assign w_instr  = r_imem[r_pc[IMEM_AW+1:2]];
  assign w_op     = w_instr[31:26];
  assign w_rs     = w_instr[25:21];
  assign w_rt     = w_instr[20:16];
  assign w_rd     = w_instr[15:11];
  assign w_shamt  = w_instr[10:6];
  assign w_funct  = w_instr[5:0];
  assign w_imm    = w_instr[15:0];
  assign w_sext   = {{16{w_imm[15]}}, w_imm};
  assign w_zext   = {16'd0, w_imm};

  // Register reads; r0 is hardwired to zero at the read side
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

  // Data memory address: byte offset ignored, upper bits alias
  assign w_mem_addr = w_rs_val + w_sext;
  assign w_mem_idx  = w_mem_addr[DMEM_AW+1:2];

  // Next-PC candidates
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_target = w_pc_plus4 + {w_sext[29:0], 2'b00};
  assign w_j_target  = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
  assign w_branch_equal = w_is_beq && (w_rs_val == w_rt_val);

  // Execute: decode opcode/funct into write-back, store and control flow
  always_comb begin
    w_reg_we  = 1'b0;
    w_wr_addr = w_rt;
    w_wr_data = 32'd0;
    w_mem_we  = 1'b0;
    w_is_beq  = 1'b0;
    w_is_j    = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_wr_addr = w_rd;
        case (w_funct)
          FN_ADD: begin w_reg_we = 1'b1; w_wr_data = w_rs_val + w_rt_val; end
          FN_SUB: begin w_reg_we = 1'b1; w_wr_data = w_rs_val - w_rt_val; end
          FN_AND: begin w_reg_we = 1'b1; w_wr_data = w_rs_val & w_rt_val; end
          FN_OR:  begin w_reg_we = 1'b1; w_wr_data = w_rs_val | w_rt_val; end
          FN_SLT: begin
            w_reg_we  = 1'b1;
            w_wr_data = {31'd0, ($signed(w_rs_val) < $signed(w_rt_val))};
          end
          default: ;
        endcase
      end
      OP_ADDI: begin w_reg_we = 1'b1; w_wr_data = w_rs_val + w_sext; end
      OP_SLTI: begin
        w_reg_we  = 1'b1;
        w_wr_data = {31'd0, ($signed(w_rs_val) < $signed(w_sext))};
      end
      OP_ANDI: begin w_reg_we = 1'b1; w_wr_data = w_rs_val & w_zext; end
      OP_ORI:  begin w_reg_we = 1'b1; w_wr_data = w_rs_val | w_zext; end
      OP_LW:   begin w_reg_we = 1'b1; w_wr_data = r_dmem[w_mem_idx]; end
      OP_SW:   w_mem_we = 1'b1;
      OP_BEQ:  w_is_beq = 1'b1;
      OP_J:    w_is_j   = 1'b1;
      default: ;
    endcase
  end

  // Next-PC priority: jump, taken branch, sequential
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_is_j) begin
      w_pc_next = w_j_target;
    end else if (w_branch_equal) begin
      w_pc_next = w_br_target;
    end
  end

  // Program counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= 32'd0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Instruction memory load port; contents survive reset
  always_ff @(posedge clk) begin
    if (imem_we) begin
      r_imem[IMEM_AW'(imem_waddr)] <= imem_wdata;
    end
  end

  // Register file write-back; reset clears all and overrides any write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_reg_we && (w_wr_addr != 5'd0)) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  // Data memory store; reset clears all and suppresses the store
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        r_dmem[i] <= 32'd0;
      end
    end else if (w_mem_we) begin
      r_dmem[w_mem_idx] <= w_rt_val;
    end
  end

  assign dbg_reg_data    = (dbg_reg_addr == 5'd0) ? 32'd0 : r_regs[dbg_reg_addr];
  assign pc              = r_pc;
  assign instruction     = w_instr;
  assign signal_extended = w_sext;
  assign branch_equal    = w_branch_equal;

  assign w_unused = &{1'b0, w_shamt, w_mem_addr[31:DMEM_AW+2], w_mem_addr[1:0]};

endmodule

// File: tb/tb_jericalla_fetch_core.sv
// Directed bench for jericalla_fetch_core with an expectation queue.
module tb_jericalla_fetch_core;

  logic        clk;
  logic        rst_n;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_data;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] signal_extended;
  logic        branch_equal;

  jericalla_fetch_core dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_we         (imem_we),
    .imem_waddr      (imem_waddr),
    .imem_wdata      (imem_wdata),
    .dbg_reg_addr    (dbg_reg_addr),
    .dbg_reg_data    (dbg_reg_data),
    .pc              (pc),
    .instruction     (instruction),
    .signal_extended (signal_extended),
    .branch_equal    (branch_equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] prog [64];
  logic [31:0] v;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic push(input string tag, input logic [31:0] e);
    sb_t it;
    it.tag = tag;
    it.exp = e;
    sb_q.push_back(it);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t it;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow: observed %h with no expectation queued", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] val);
    dbg_reg_addr = a;
    #1;
    val = dbg_reg_data;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] e);
    logic [31:0] t;
    push(tag, e);
    rd(a, t);
    check(t);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
  endtask

  // Loads all 64 words under reset; leaves rst_n low at a falling edge
  task automatic load_prog();
    rst_n   = 1'b0;
    imem_we = 1'b1;
    for (int i = 0; i < 64; i++) begin
      imem_waddr = 6'(i);
      imem_wdata = prog[i];
      tick();
    end
    imem_we = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    imem_we      = 1'b0;
    imem_waddr   = 6'd0;
    imem_wdata   = 32'd0;
    dbg_reg_addr = 5'd0;
    @(negedge clk);

    // Reset / idle with empty instruction memory
    clear_prog();
    load_prog();
    push("rst_pc", 32'd0);           check(pc);
    push("rst_instr", 32'd0);        check(instruction);
    for (int i = 0; i < 32; i++) begin
      dbg_reg_addr = 5'(i);
      @(negedge clk);
      push("rst_reg", 32'd0);
      check(dbg_reg_data);
    end
    rst_n = 1'b1;
    push("nop_pc4", 32'd4);  tick(); check(pc);
    push("nop_pc8", 32'd8);  tick(); check(pc);
    push("nop_pc12", 32'd12); tick(); check(pc);

    // ALU program
    clear_prog();
    prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    prog[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    prog[3]  = enc_r(5'd1, 5'd2, 5'd4, 6'h22);
    prog[4]  = enc_r(5'd2, 5'd1, 5'd5, 6'h2A);
    prog[5]  = enc_i(6'h0C, 5'd2, 5'd6, 16'hFFFF);
    prog[6]  = enc_i(6'h0D, 5'd1, 5'd11, 16'h8000);
    prog[7]  = enc_r(5'd1, 5'd2, 5'd12, 6'h24);
    prog[8]  = enc_r(5'd1, 5'd2, 5'd13, 6'h25);
    prog[9]  = enc_r(5'd1, 5'd2, 5'd14, 6'h2A);
    prog[10] = enc_i(6'h0A, 5'd2, 5'd15, 16'h0000);
    prog[11] = enc_r(5'd2, 5'd1, 5'd16, 6'h22);
    prog[12] = enc_r(5'd1, 5'd2, 5'd17, 6'h21);
    load_prog();
    rst_n = 1'b1;
    push("alu_instr0", prog[0]); check(instruction);
    tick();
    chk_reg("alu_r1_latency", 5'd1, 32'd5);
    push("alu_sext_addi", 32'hFFFF_FFFD); check(signal_extended);
    repeat (12) tick();
    chk_reg("alu_add_r3", 5'd3, 32'd2);
    chk_reg("alu_sub_r4", 5'd4, 32'd8);
    chk_reg("alu_slt_r5", 5'd5, 32'd1);
    chk_reg("alu_andi_r6", 5'd6, 32'h0000_FFFD);
    chk_reg("alu_ori_r11", 5'd11, 32'h0000_8005);
    chk_reg("alu_and_r12", 5'd12, 32'd5);
    chk_reg("alu_or_r13", 5'd13, 32'hFFFF_FFFD);
    chk_reg("alu_slt_r14", 5'd14, 32'd0);
    chk_reg("alu_slti_r15", 5'd15, 32'd1);
    chk_reg("alu_sub_r16", 5'd16, 32'hFFFF_FFF8);
    chk_reg("alu_badfn_r17", 5'd17, 32'd0);

    // Memory program
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0040);
    prog[1] = enc_i(6'h2B, 5'd1, 5'd1, 16'h0004);
    prog[2] = enc_i(6'h23, 5'd1, 5'd7, 16'h0004);
    prog[3] = enc_r(5'd7, 5'd7, 5'd10, 6'h20);
    prog[4] = enc_i(6'h08, 5'd0, 5'd8, 16'd1);
    prog[5] = enc_i(6'h23, 5'd0, 5'd8, 16'h0100);
    prog[6] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0100);
    prog[7] = enc_i(6'h23, 5'd0, 5'd9, 16'h0000);
    load_prog();
    rst_n = 1'b1;
    repeat (8) tick();
    chk_reg("mem_lw_r7", 5'd7, 32'h40);
    chk_reg("mem_lw_use_r10", 5'd10, 32'h80);
    chk_reg("mem_alias_lw_r8", 5'd8, 32'd0);
    chk_reg("mem_alias_sw_r9", 5'd9, 32'h40);

    // Branch program
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
    prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    prog[4] = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
    prog[5] = enc_i(6'h08, 5'd0, 5'd20, 16'd1);
    prog[6] = enc_i(6'h08, 5'd0, 5'd20, 16'd1);
    prog[7] = enc_i(6'h08, 5'd0, 5'd2, 16'd8);
    prog[8] = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
    prog[9] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    load_prog();
    rst_n = 1'b1;
    tick(); tick();
    push("br_nonbeq_flag", 32'd0); check({31'd0, branch_equal});
    tick(); tick();
    push("br_at_0x10", 32'h10);    check(pc);
    push("br_taken_flag", 32'd1);  check({31'd0, branch_equal});
    push("br_taken_pc", 32'h1C);   tick(); check(pc);
    chk_reg("br_skipped_r20", 5'd20, 32'd0);
    tick();
    push("br_nt_flag", 32'd0);     check({31'd0, branch_equal});
    push("br_nt_pc", 32'h24);      tick(); check(pc);
    push("br_back_flag", 32'd1);   check({31'd0, branch_equal});
    push("br_back_pc1", 32'h24);   tick(); check(pc);
    push("br_back_pc2", 32'h24);   tick(); check(pc);

    // Jump, r0 and invalid opcode
    clear_prog();
    prog[0] = {6'h02, 26'h000003};
    prog[1] = enc_i(6'h08, 5'd0, 5'd3, 16'd1);
    prog[2] = enc_i(6'h08, 5'd0, 5'd3, 16'd1);
    prog[3] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    prog[4] = enc_i(6'h3F, 5'd1, 5'd4, 16'h1234);
    prog[5] = enc_i(6'h08, 5'd0, 5'd5, 16'd1);
    load_prog();
    rst_n = 1'b1;
    push("j_pc", 32'h0C);          tick(); check(pc);
    push("inv_pc", 32'h10);        tick(); check(pc);
    chk_reg("r0_reads_zero", 5'd0, 32'd0);
    push("inv_sext", 32'h0000_1234); check(signal_extended);
    push("inv_next_pc", 32'h14);   tick(); check(pc);
    chk_reg("inv_r4", 5'd4, 32'd0);
    chk_reg("j_skipped_r3", 5'd3, 32'd0);
    tick();
    chk_reg("r0_source_r5", 5'd5, 32'd1);

    // Reset mid-run on the edge of a store
    clear_prog();
    prog[0] = enc_i(6'h23, 5'd0, 5'd2, 16'h0000);
    prog[1] = enc_i(6'h08, 5'd0, 5'd1, 16'h0055);
    prog[2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0000);
    load_prog();
    rst_n = 1'b1;
    tick(); tick();
    chk_reg("mid_r1_before", 5'd1, 32'h55);
    push("mid_pc_at_sw", 32'h08);  check(pc);
    rst_n = 1'b0;
    tick();
    push("mid_rst_pc", 32'd0);     check(pc);
    chk_reg("mid_rst_r1", 5'd1, 32'd0);
    rst_n = 1'b1;
    tick();
    chk_reg("mid_no_store_r2", 5'd2, 32'd0);
    push("mid_resume_pc", 32'd4);  check(pc);

    n_tests++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover: observed %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
